// File: rtl/morse_sender.sv
// Morse light sender: plays a captured dot/dash pattern as timed light pulses.
// Define MORSE_SENDER_REPEAT_EN to repeat the symbol (after a letter gap) while start is held.
module morse_sender #(
  parameter int MAX_LEN     = 8,
  parameter int UNIT_CYCLES = 25000000,
  parameter int DASH_UNITS  = 3
) (
  input  logic                             Clock,
  input  logic                             Resetn,
  input  logic                             start,
  input  logic [MAX_LEN-1:0]               code,
  input  logic [$clog2(MAX_LEN+1)-1:0]     length,
  output logic                             light,
  output logic                             busy,
  output logic                             done
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int DW = $clog2(UNIT_CYCLES);
  localparam logic [DW-1:0] DIV_LAST  = DW'(UNIT_CYCLES - 1);
  localparam logic [2:0]    DASH_LAST = 3'(DASH_UNITS - 1);
  localparam logic [2:0]    LGAP_LAST = 3'd2;
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

`ifdef MORSE_SENDER_REPEAT_EN
  typedef enum logic [2:0] {IDLE, ELEM, GAP, HOLD, LGAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ELEM, GAP, HOLD} state_t;
`endif

  state_t             state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic [2:0]         unit_q, unit_d;
  logic [MAX_LEN-1:0] code_q, code_d;
  logic [LW-1:0]      rem_q, rem_d;
  logic               light_q, light_d;
  logic               done_q, done_d;
  logic               tick;
  logic               elem_end;
  logic [LW-1:0]      len_clamped;
`ifdef MORSE_SENDER_REPEAT_EN
  logic [MAX_LEN-1:0] code_copy_q, code_copy_d;
  logic [LW-1:0]      len_copy_q, len_copy_d;
`endif

  assign tick        = (div_q == DIV_LAST);
  assign elem_end    = tick && (!code_q[0] || (unit_q == DASH_LAST));
  assign len_clamped = (length > LEN_MAX) ? LEN_MAX : length;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      div_q       <= '0;
      unit_q      <= '0;
      code_q      <= '0;
      rem_q       <= '0;
      light_q     <= 1'b0;
      done_q      <= 1'b0;
`ifdef MORSE_SENDER_REPEAT_EN
      code_copy_q <= '0;
      len_copy_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      unit_q      <= unit_d;
      code_q      <= code_d;
      rem_q       <= rem_d;
      light_q     <= light_d;
      done_q      <= done_d;
`ifdef MORSE_SENDER_REPEAT_EN
      code_copy_q <= code_copy_d;
      len_copy_q  <= len_copy_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + DW'(1);
    unit_d      = tick ? unit_q + 3'd1 : unit_q;
    code_d      = code_q;
    rem_d       = rem_q;
    light_d     = light_q;
    done_d      = 1'b0;
`ifdef MORSE_SENDER_REPEAT_EN
    code_copy_d = code_copy_q;
    len_copy_d  = len_copy_q;
`endif
    case (state_q)
      IDLE: begin
        div_d   = '0;
        unit_d  = '0;
        light_d = 1'b0;
        if (start) begin
          if (length == '0) begin
            done_d  = 1'b1;
            state_d = HOLD;
          end else begin
            code_d  = code;
            rem_d   = len_clamped;
            light_d = 1'b1;
            state_d = ELEM;
`ifdef MORSE_SENDER_REPEAT_EN
            code_copy_d = code;
            len_copy_d  = len_clamped;
`endif
          end
        end
      end
      ELEM: begin
        if (elem_end) begin
          div_d   = '0;
          unit_d  = '0;
          light_d = 1'b0;
          if (rem_q > LW'(1)) begin
            code_d  = code_q >> 1;
            rem_d   = rem_q - LW'(1);
            state_d = GAP;
          end else begin
            done_d  = 1'b1;
`ifdef MORSE_SENDER_REPEAT_EN
            state_d = LGAP;
`else
            state_d = HOLD;
`endif
          end
        end
      end
      GAP: begin
        if (tick) begin
          div_d   = '0;
          unit_d  = '0;
          light_d = 1'b1;
          state_d = ELEM;
        end
      end
      HOLD: begin
        div_d   = '0;
        unit_d  = '0;
        light_d = 1'b0;
        if (!start) state_d = IDLE;
      end
`ifdef MORSE_SENDER_REPEAT_EN
      LGAP: begin
        if (tick && (unit_q == LGAP_LAST)) begin
          div_d  = '0;
          unit_d = '0;
          if (start) begin
            code_d  = code_copy_q;
            rem_d   = len_copy_q;
            light_d = 1'b1;
            state_d = ELEM;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      default: begin
        div_d   = '0;
        unit_d  = '0;
        light_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == ELEM) || (state_q == GAP);
`ifdef MORSE_SENDER_REPEAT_EN
    if (state_q == LGAP) busy = 1'b1;
`endif
  end

  assign light = light_q;
  assign done  = done_q;

endmodule
